// File: rtl/led_output_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_output_driver_pkg
// Description : Shared IO-peripheral constants for the LED output driver.
// Revision    : 1.0 - initial release
// ============================================================================
package led_output_driver_pkg;

   localparam logic [31:0] LED_OUTPUT_CONTROL_ADDRESS = 32'h0000_0104;

   // Control register field positions
   localparam int DUTY_LSB         = 0;
   localparam int DUTY_MSB         = 3;
   localparam int BLINK_ENABLE_BIT = 4;
   localparam int BLINK_RATE_LSB   = 5;
   localparam int BLINK_RATE_MSB   = 6;
   localparam int INVERT_BIT       = 7;

   localparam logic [7:0] CONTROL_RESET_VALUE = 8'h0F;
   localparam logic [3:0] DUTY_FULL           = 4'hF;

endpackage
`default_nettype wire

// File: rtl/led_output_driver_io_register_write_decode.sv
`default_nettype none
// ============================================================================
// Module      : io_register_write_decode
// Description : Write-strobe decode for a single IO-space register address.
// Revision    : 1.0 - initial release
// ============================================================================
module io_register_write_decode #(
   parameter logic [31:0] ADDRESS = 32'h0000_0000
) (
   input  logic [31:0] addressBus,
   input  logic        readRequest,
   input  logic        mio,
   input  logic        enable,
   output logic        writeStrobe
);

   assign writeStrobe = enable && !readRequest && !mio && (addressBus == ADDRESS);

endmodule
`default_nettype wire

// File: rtl/led_output_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_output_driver
// Description : Applies PWM brightness, blinking and inversion to ledState.
// Revision    : 1.0 - initial release
// ============================================================================
module led_output_driver
   import led_output_driver_pkg::*;
#(
   parameter logic [31:0] CONTROL_ADDRESS  = LED_OUTPUT_CONTROL_ADDRESS,
   parameter int          BLINK_BASE_SHIFT = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addressBus,
   input  logic [7:0]  dataBusIn,
   input  logic        readRequest,
   input  logic        mio,
   input  logic        enable,
   input  logic [7:0]  ledState,
   output logic [7:0]  ledPins
);

   localparam int BLINK_WIDTH = BLINK_BASE_SHIFT + 4;
   localparam logic [BLINK_WIDTH-1:0] c_blinkOne = {{(BLINK_WIDTH-1){1'b0}}, 1'b1};

   logic [7:0]             r_controlReg;
   logic [3:0]             r_pwmCounter;
   logic [BLINK_WIDTH-1:0] r_blinkCounter;

   logic       w_writeStrobe;
   logic [3:0] w_duty;
   logic       w_blinkEnable;
   logic [1:0] w_blinkRate;
   logic       w_invert;
   logic       w_pwmOn;
   logic       w_blinkPhase;
   logic       w_blinkOn;
   logic [7:0] w_ledNext;

   io_register_write_decode #(
      .ADDRESS (CONTROL_ADDRESS)
   ) u_write_decode (
      .addressBus  (addressBus),
      .readRequest (readRequest),
      .mio         (mio),
      .enable      (enable),
      .writeStrobe (w_writeStrobe)
   );

   assign w_duty        = r_controlReg[DUTY_MSB:DUTY_LSB];
   assign w_blinkEnable = r_controlReg[BLINK_ENABLE_BIT];
   assign w_blinkRate   = r_controlReg[BLINK_RATE_MSB:BLINK_RATE_LSB];
   assign w_invert      = r_controlReg[INVERT_BIT];

   assign w_pwmOn = (w_duty == DUTY_FULL) || (r_pwmCounter < w_duty);

   // Each rate step doubles the blink half-period.
   always_comb begin
      w_blinkPhase = 1'b0;
      unique case (w_blinkRate)
         2'd0: w_blinkPhase = r_blinkCounter[BLINK_BASE_SHIFT];
         2'd1: w_blinkPhase = r_blinkCounter[BLINK_BASE_SHIFT + 1];
         2'd2: w_blinkPhase = r_blinkCounter[BLINK_BASE_SHIFT + 2];
         2'd3: w_blinkPhase = r_blinkCounter[BLINK_BASE_SHIFT + 3];
         default: w_blinkPhase = 1'b0;
      endcase
   end

   assign w_blinkOn = !w_blinkEnable || !w_blinkPhase;
   assign w_ledNext = (ledState & {8{w_pwmOn & w_blinkOn}}) ^ {8{w_invert}};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_controlReg   <= CONTROL_RESET_VALUE;
         r_pwmCounter   <= 4'd0;
         r_blinkCounter <= '0;
         ledPins        <= 8'h00;
      end else begin
         if (w_writeStrobe) begin
            r_controlReg <= dataBusIn;
         end
         r_pwmCounter   <= r_pwmCounter + 4'd1;
         r_blinkCounter <= r_blinkCounter + c_blinkOne;
         ledPins        <= w_ledNext;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_output_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_output_driver
// Description : Randomized self-checking bench against a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_output_driver;

   localparam logic [31:0] c_addr = 32'h0000_0104;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] addressBus;
   logic [7:0]  dataBusIn;
   logic        readRequest;
   logic        mio;
   logic        enable;
   logic [7:0]  ledState;
   logic [7:0]  ledPins;

   int total_checks = 0;
   int pass_checks  = 0;

   // Reference state: control value and cycles elapsed since the last reset.
   logic [7:0] m_ctrl;
   int         m_t;
   logic [7:0] m_exp;

   led_output_driver #(
      .CONTROL_ADDRESS  (c_addr),
      .BLINK_BASE_SHIFT (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .addressBus  (addressBus),
      .dataBusIn   (dataBusIn),
      .readRequest (readRequest),
      .mio         (mio),
      .enable      (enable),
      .ledState    (ledState),
      .ledPins     (ledPins)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_checks++;
      if (obs === exp) pass_checks++;
      else $display("FAIL %s: ledPins=%02h expected=%02h (t=%0d ctrl=%02h)", tag, obs, exp, m_t, m_ctrl);
   endtask

   task automatic idle_bus();
      addressBus  = $urandom;
      if (addressBus == c_addr) addressBus = 32'h0;
      dataBusIn   = $urandom;
      readRequest = 1'($urandom);
      mio         = 1'($urandom);
      enable      = 1'($urandom);
   endtask

   task automatic tick(input string tag);
      logic [3:0] duty;
      logic       pwm_on, blink_on, wr;
      logic [7:0] nxt;
      duty     = m_ctrl[3:0];
      pwm_on   = (duty == 4'hF) || ((m_t % 16) < int'(duty));
      blink_on = !m_ctrl[4] || (((m_t / (4 << m_ctrl[6:5])) % 2) == 0);
      nxt      = (ledState & {8{pwm_on & blink_on}}) ^ {8{m_ctrl[7]}};
      wr       = (addressBus == c_addr) && !readRequest && !mio && enable;
      @(posedge clock);
      #1;
      if (reset) begin
         m_ctrl = 8'h0F;
         m_t    = 0;
         m_exp  = 8'h00;
      end else begin
         m_exp = nxt;
         if (wr) m_ctrl = dataBusIn;
         m_t++;
      end
      check(tag, ledPins, m_exp);
   endtask

   task automatic write_ctrl(input logic [7:0] data);
      addressBus  = c_addr;
      dataBusIn   = data;
      readRequest = 1'b0;
      mio         = 1'b0;
      enable      = 1'b1;
      tick("write");
      idle_bus();
   endtask

   // One write attempt of 8'h00 with exactly one field wrong.
   task automatic bad_write(input int kind);
      addressBus  = c_addr;
      dataBusIn   = 8'h00;
      readRequest = 1'b0;
      mio         = 1'b0;
      enable      = 1'b1;
      case (kind)
         0: addressBus  = c_addr + 32'd1;
         1: mio         = 1'b1;
         2: readRequest = 1'b1;
         default: enable = 1'b0;
      endcase
      tick("bad_write");
      idle_bus();
   endtask

   initial begin
      m_ctrl = 8'h0F;
      m_t    = 0;
      m_exp  = 8'h00;
      idle_bus();

      // Reset with a pattern present, then track a changing ledState.
      reset    = 1'b1;
      ledState = 8'hA5;
      tick("reset");
      tick("reset");
      reset = 1'b0;
      tick("first_after_reset");
      for (int i = 0; i < 12; i++) begin
         ledState = $urandom;
         tick("track");
      end

      // Half duty, then zero duty.
      ledState = 8'hFF;
      write_ctrl(8'h08);
      for (int i = 0; i < 40; i++) tick("duty8");
      write_ctrl(8'h00);
      for (int i = 0; i < 20; i++) begin
         ledState = $urandom;
         tick("duty0");
      end

      // Back to default, then near-miss writes must be ignored.
      write_ctrl(8'h0F);
      for (int k = 0; k < 4; k++) begin
         ledState = $urandom;
         bad_write(k);
         for (int i = 0; i < 3; i++) begin
            ledState = $urandom;
            tick("after_bad");
         end
      end

      // Blink rate 0 and rate 3.
      ledState = 8'h3C;
      write_ctrl(8'h1F);
      for (int i = 0; i < 24; i++) tick("blink_r0");
      write_ctrl(8'h7F);
      for (int i = 0; i < 80; i++) tick("blink_r3");

      // Inversion, full duty and zero duty.
      ledState = 8'h0F;
      write_ctrl(8'h8F);
      for (int i = 0; i < 5; i++) tick("invert");
      write_ctrl(8'h80);
      for (int i = 0; i < 5; i++) tick("invert_off");

      // Reset mid-blink coinciding with a write: reset must win.
      write_ctrl(8'h9F);
      for (int i = 0; i < 7; i++) tick("pre_reset");
      addressBus  = c_addr;
      dataBusIn   = 8'h00;
      readRequest = 1'b0;
      mio         = 1'b0;
      enable      = 1'b1;
      reset       = 1'b1;
      tick("reset_vs_write");
      reset = 1'b0;
      idle_bus();
      for (int i = 0; i < 30; i++) begin
         ledState = $urandom;
         tick("post_reset");
      end

      // Random mix of writes, near-misses, resets and pattern changes.
      for (int i = 0; i < 400; i++) begin
         int r;
         ledState = $urandom;
         r = $urandom_range(0, 15);
         if (r < 2) write_ctrl(8'($urandom));
         else if (r == 2) bad_write($urandom_range(0, 3));
         else if (r == 3 && $urandom_range(0, 7) == 0) begin
            reset = 1'b1;
            tick("rand_reset");
            reset = 1'b0;
         end else begin
            idle_bus();
            tick("rand");
         end
      end

      $display("%0d/%0d checks passed", pass_checks, total_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/led_output_driver.md
Name: led_output_driver

Overview:
- Downstream stage of the LED controller: consumes its registered 8-bit ledState and drives the physical LED pins.
- Adds global PWM brightness, optional blinking and output polarity inversion.
- Settings live in one 8-bit control register, written through the same CPU IO write transaction as the LED controller, at its own address.
- Sits between the LED controller and the board pins.

Parameters:
- CONTROL_ADDRESS, 32'h0000_0104, IO address of the control register.
- BLINK_BASE_SHIFT, 20, blink-counter bit index used for the fastest blink rate; benches override it to 2.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- addressBus  input  32  CPU address bus.
- dataBusIn  input  8  CPU write data.
- readRequest  input  1  1 = read, 0 = write.
- mio  input  1  1 = memory, 0 = IO space.
- enable  input  1  bus cycle valid.
- ledState  input  8  LED on/off pattern from the LED controller.
- ledPins  output  8  registered physical LED drive.

Behaviour:
- Control register controlReg[7:0] fields:
  - [3:0] duty
  - [4] blinkEnable
  - [6:5] blinkRate
  - [7] invert
- Reset values (reset high at a rising edge):
  - controlReg = 8'h0F
  - pwmCounter = 0
  - blinkCounter = 0
  - ledPins = 8'h00
  - Reset has priority over every other event, including a simultaneous bus write.
- Register write: at a rising edge where addressBus == CONTROL_ADDRESS, readRequest == 0, mio == 0 and enable == 1, controlReg <= dataBusIn. Otherwise controlReg holds. There is no read-back path.
- pwmCounter: 4-bit, free-running, increments every cycle, wraps 15 -> 0. Not cleared by control writes.
- blinkCounter: (BLINK_BASE_SHIFT+4) bits, free-running, wraps to 0. Not cleared by control writes.
- pwmOn = (duty == 15) or (pwmCounter < duty).
  - duty 0: always off.
  - duty 1..14: on for duty out of every 16 cycles.
  - duty 15: always on.
- blinkOn = !blinkEnable or (blinkCounter[BLINK_BASE_SHIFT + blinkRate] == 0).
  - Half-period = 2^(BLINK_BASE_SHIFT + blinkRate) cycles.
- Output update every cycle out of reset: ledPins <= (ledState & {8{pwmOn & blinkOn}}) ^ {8{invert}}.
  - pwmOn and blinkOn are evaluated from the current counter and controlReg values.
- Latency:
  - A ledState change appears on ledPins at the next rising edge (1 cycle).
  - A control write at edge N affects ledPins from edge N+1.
- After reset with no writes, ledPins equals ledState delayed by 1 cycle.
- Reset asserted mid-blink or mid-PWM: counters restart from 0 and ledPins is 0 during reset. The first post-reset edge drives ledState with the default control.

Decomposition:
- Shared package / header with the other IO peripherals holds:
  - the LED_OUTPUT_CONTROL_ADDRESS constant
  - field index constants: DUTY_LSB/MSB, BLINK_ENABLE_BIT, BLINK_RATE_LSB/MSB, INVERT_BIT
  - the CONTROL_RESET_VALUE 8'h0F
- One natural sub-module, io_register_write_decode: address/readRequest/mio/enable match producing a write strobe. It is reusable by the LED controller and future IO peripherals.
- Counters and output logic stay in the top module.

Test Plan (BLINK_BASE_SHIFT = 2):
1. Reset high 2 cycles with ledState = 8'hA5 -> ledPins = 8'h00 during reset. First edge after release ledPins = 8'hA5; it then tracks ledState with 1-cycle latency.
2. Write 8'h08 (duty 8) with ledState = 8'hFF -> ledPins = 8'hFF exactly while pwmCounter is 0..7 and 8'h00 for 8..15, repeating every 16 cycles. Write 8'h00 -> ledPins held at 8'h00.
3. Attempted writes of 8'h00, each with exactly one mismatch (address CONTROL_ADDRESS+1, mio = 1, readRequest = 1, enable = 0) -> controlReg stays 8'h0F and ledPins keeps following ledState.
4. Write 8'h1F (blink, rate 0), ledState = 8'h3C -> ledPins alternates 8'h3C for 4 cycles and 8'h00 for 4 cycles. Write 8'h7F (rate 3) -> half-period 32 cycles.
5. Write 8'h8F with ledState = 8'h0F -> ledPins = 8'hF0. Write 8'h80 -> ledPins = 8'hFF.
6. Write 8'h9F, then assert reset mid-blink in the same cycle as a write of 8'h00 -> reset wins. After release controlReg = 8'h0F, counters restart from 0, and ledPins = ledState with no blinking.
